mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (registered read, one access per clock selected by wr/en) between two requesters.
- Round-robin arbitration with a req/gnt handshake; accepts one access per cycle, back-to-back.
- Registers the winning command onto the RAM control/address/data pins.
- Returns read data to the originating requester with a fixed latency and a per-requester rvalid strobe.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Issues one registered access per cycle and routes read data back with a fixed two-cycle latency.
module mem_port_arbiter #(
  parameter int ADDR_LINES = 10,
  parameter int LOC_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_LINES-1:0] addr0,
  input  logic [LOC_SIZE-1:0]   wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [LOC_SIZE-1:0]   rdata0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_LINES-1:0] addr1,
  input  logic [LOC_SIZE-1:0]   wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [LOC_SIZE-1:0]   rdata1,

  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_LINES-1:0] mem_rd_addr,
  output logic [ADDR_LINES-1:0] mem_wr_addr,
  output logic [LOC_SIZE-1:0]   mem_wr_data,
  input  logic [LOC_SIZE-1:0]   mem_rd_data
);

  // ptr names the requester that wins when both are asking.
  logic                  ptr;
  logic [1:0]            win;
  logic                  any_gnt;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_LINES-1:0] sel_addr;
  logic [LOC_SIZE-1:0]   sel_wdata;

  logic                  vld_p0;
  logic                  id_p0;
  logic                  vld_p1;
  logic                  id_p1;

  function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input logic p);
    logic [1:0] g;
    g = 2'b00;
    if (r0 && (!r1 || !p))
      g = 2'b01;
    else if (r1)
      g = 2'b10;
    return g;
  endfunction

  assign win       = rst ? 2'b00 : arbitrate(req0, req1, ptr);
  assign gnt0      = win[0];
  assign gnt1      = win[1];
  assign any_gnt   = win[0] | win[1];
  assign sel       = win[1];
  assign sel_we    = sel ? we1    : we0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  // Stage p0: winning command registered onto the RAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      vld_p0      <= 1'b0;
      id_p0       <= 1'b0;
    end else begin
      mem_en <= any_gnt;
      mem_wr <= any_gnt & sel_we;
      vld_p0 <= any_gnt & ~sel_we;
      id_p0  <= sel;
      if (any_gnt) begin
        ptr         <= ~sel;
        mem_rd_addr <= sel_addr;
        mem_wr_addr <= sel_addr;
        mem_wr_data <= sel_wdata;
      end
    end
  end

  // Stage p1: tag lines up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
    end
  end

  assign rvalid0 = ~rst & vld_p1 & ~id_p1;
  assign rvalid1 = ~rst & vld_p1 &  id_p1;
  assign rdata0  = mem_rd_data;
  assign rdata1  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read RAM attached to its pins.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, gnt0, rvalid0;
  logic [9:0]  addr0;
  logic [31:0] wdata0, rdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [9:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic        mem_en, mem_wr;
  logic [9:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] ram [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_LINES(10), .LOC_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_rd_addr(mem_rd_addr),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en)
      ram[ld_addr] <= ld_data;
    else if (mem_en && mem_wr)
      ram[mem_wr_addr] <= mem_wr_data;
    if (mem_en && !mem_wr)
      mem_rd_data <= ram[mem_rd_addr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_pins(input string tag);
    chk1({tag, "_mem_en"}, mem_en, 1'b0);
    chk1({tag, "_mem_wr"}, mem_wr, 1'b0);
    chk1({tag, "_rvalid0"}, rvalid0, 1'b0);
    chk1({tag, "_rvalid1"}, rvalid1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1; wdata0 = 32'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd2; wdata1 = 32'd0;
    ld_en = 1'b1; ld_addr = 10'd1; ld_data = 32'd11;

    // Reset held for two sampled edges with both requests high.
    #1;
    chk1("rst_pre_gnt0", gnt0, 1'b0);
    chk1("rst_pre_gnt1", gnt1, 1'b0);
    step();
    ld_addr = 10'd2; ld_data = 32'd22;
    @(negedge clk);
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk_idle_pins("rst");
    step();
    rst = 1'b0; ld_en = 1'b0;

    // Contention: six reads, alternating grants starting with requester 0.
    for (int k = 0; k < 8; k++) begin
      logic g, e0, e1, men, rv0, rv1;
      if (k == 6) begin req0 = 1'b0; req1 = 1'b0; end
      g   = (k < 6);
      e0  = g && (k % 2 == 0);
      e1  = g && (k % 2 == 1);
      men = (k >= 1) && (k <= 6);
      rv0 = (k >= 2) && (k % 2 == 0);
      rv1 = (k >= 2) && (k % 2 == 1);
      @(negedge clk);
      chk1($sformatf("cont%0d_gnt0", k), gnt0, e0);
      chk1($sformatf("cont%0d_gnt1", k), gnt1, e1);
      chk1($sformatf("cont%0d_mem_en", k), mem_en, men);
      chk1($sformatf("cont%0d_rvalid0", k), rvalid0, rv0);
      chk1($sformatf("cont%0d_rvalid1", k), rvalid1, rv1);
      if (men) begin
        chk1($sformatf("cont%0d_mem_wr", k), mem_wr, 1'b0);
        chkw($sformatf("cont%0d_rd_addr", k), 32'(mem_rd_addr), ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
      end
      if (rv0) chkw($sformatf("cont%0d_rdata0", k), rdata0, 32'd11);
      if (rv1) chkw($sformatf("cont%0d_rdata1", k), rdata1, 32'd22);
      step();
    end

    // Skip idle requester: pointer at 0, only req1 asks.
    req1 = 1'b1; addr1 = 10'd2; we1 = 1'b0;
    @(negedge clk);
    chk1("skip_gnt1", gnt1, 1'b1);
    chk1("skip_gnt0", gnt0, 1'b0);
    step();
    req0 = 1'b1; addr0 = 10'd1; we0 = 1'b0;
    @(negedge clk);
    chk1("skip_next_gnt0", gnt0, 1'b1);
    chk1("skip_next_gnt1", gnt1, 1'b0);
    chk1("skip_mem_en", mem_en, 1'b1);
    chkw("skip_rd_addr", 32'(mem_rd_addr), 32'd2);
    step();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk1("skip_mem_en2", mem_en, 1'b1);
    chkw("skip_rd_addr2", 32'(mem_rd_addr), 32'd1);
    chk1("skip_rvalid1", rvalid1, 1'b1);
    chkw("skip_rdata1", rdata1, 32'd22);
    step();
    @(negedge clk);
    chk1("skip_rvalid0", rvalid0, 1'b1);
    chkw("skip_rdata0", rdata0, 32'd11);
    chk1("skip_mem_en3", mem_en, 1'b0);
    step();

    // Single write then read by requester 0.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk1("wr_gnt0", gnt0, 1'b1);
    step();
    we0 = 1'b0;
    @(negedge clk);
    chk1("rd_gnt0", gnt0, 1'b1);
    chk1("wr_mem_en", mem_en, 1'b1);
    chk1("wr_mem_wr", mem_wr, 1'b1);
    chkw("wr_mem_wr_addr", 32'(mem_wr_addr), 32'd5);
    chkw("wr_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
    chk1("wr_rvalid0", rvalid0, 1'b0);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk1("rd_mem_en", mem_en, 1'b1);
    chk1("rd_mem_wr", mem_wr, 1'b0);
    chkw("rd_mem_rd_addr", 32'(mem_rd_addr), 32'd5);
    chk1("rd_rvalid0_early", rvalid0, 1'b0);
    step();
    @(negedge clk);
    chk1("rd_rvalid0", rvalid0, 1'b1);
    chkw("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk1("rd_rvalid1", rvalid1, 1'b0);
    step();
    @(negedge clk);
    chk1("rd_rvalid0_once", rvalid0, 1'b0);
    step();

    // Read-after-write: requester 1 writes, requester 0 reads the next cycle.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd9; wdata1 = 32'd7;
    @(negedge clk);
    chk1("raw_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'd9;
    @(negedge clk);
    chk1("raw_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk1("raw_rvalid1_a", rvalid1, 1'b0);
    chk1("raw_rvalid0_early", rvalid0, 1'b0);
    step();
    @(negedge clk);
    chk1("raw_rvalid0", rvalid0, 1'b1);
    chkw("raw_rdata0", rdata0, 32'd7);
    chk1("raw_rvalid1_b", rvalid1, 1'b0);
    step();

    // Reset one cycle after a read grant discards the read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
    @(negedge clk);
    chk1("mrst_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("mrst_in_gnt0", gnt0, 1'b0);
    chk1("mrst_in_mem_en", mem_en, 1'b1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_pins("mrst_after");
    chkw("mrst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chkw("mrst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chkw("mrst_wr_data", mem_wr_data, 32'd0);
    step();
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk1("mrst_late_rvalid0", rvalid0, 1'b0);
    chk1("mrst_ptr_gnt0", gnt0, 1'b1);
    chk1("mrst_ptr_gnt1", gnt1, 1'b0);
    step();
    req0 = 1'b0; req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
